// File: rtl/shift_pkg.sv
// Shared constants and entry payload type for the shift result FIFO.
package shift_pkg;

    localparam int unsigned DEFAULT_N     = 3;
    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned DEFAULT_W     = 2 ** DEFAULT_N;

    typedef struct packed {
        logic [DEFAULT_W-1:0] data;
        logic                 dir;
    } shift_entry_t;

endpackage

// File: rtl/shift_fifo_ptr.sv
// Read/write pointers, occupancy count and full/empty flags for a power-of-two FIFO.
module shift_fifo_ptr #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    // Pointers are exactly log2(DEPTH) bits wide, so wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/shift_result_fifo.sv
// Result FIFO behind the shifter: stores {data, dir} entries, flags all-zero heads.
// Optional rejected-push counter enabled by defining SHIFT_FIFO_DROP_CNT_EN.
module shift_result_fifo
    import shift_pkg::*;
#(
    parameter  int unsigned N     = DEFAULT_N,
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned W     = 2 ** N,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          in_dir,
    output logic          in_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic          out_dir,
    output logic          out_zero,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic [7:0]    drop_count
);

    // Same layout as shift_entry_t, sized by N rather than DEFAULT_N.
    typedef struct packed {
        logic [W-1:0] data;
        logic         dir;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    shift_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Storage is not reset; a push coincident with reset is simply lost.
    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr] <= entry_t'{data: in_data, dir: in_dir};
    end

    assign head     = mem[rd_ptr];
    assign out_data = head.data;
    assign out_dir  = head.dir;
    assign out_zero = out_valid && (head.data == '0);

`ifdef SHIFT_FIFO_DROP_CNT_EN
    logic [7:0] drop_reg;

    // Saturating count of pushes offered while full.
    always_ff @(posedge clk) begin
        if (reset)
            drop_reg <= '0;
        else if (in_valid && !in_ready && drop_reg != 8'hFF)
            drop_reg <= drop_reg + 8'd1;
    end

    assign drop_count = drop_reg;
`else
    assign drop_count = 8'd0;
`endif

endmodule
